// File: rtl/phase_traffic_controller_pkg.sv
// tlc_pkg: shared controller states, lane indices and the default phase table
package tlc_pkg;
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} tlc_state_e;
  localparam int LN_ES = 0;
  localparam int LN_WS = 1;
  localparam int LN_EL = 2;
  localparam int LN_WL = 3;
  localparam int LN_NS = 4;
  localparam int LN_NL = 5;
  localparam int LN_SL = 6;
  localparam int LN_SS = 7;
  localparam logic [63:0] PHASE_LANES_DEFAULT = 64'hC0_90_30_60_0A_03_05_0C;
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > d ? m : d;
  endfunction
endpackage

// File: rtl/phase_traffic_controller_if.sv
// phase_traffic_controller_if: sensor inputs and lamp/phase outputs of the controller
interface phase_traffic_controller_if #(
  parameter int NUM_LANES = 8,
  parameter int NUM_PHASES = 8
);
  logic [NUM_LANES-1:0] sensor;
  logic [NUM_LANES-1:0] green;
  logic [NUM_LANES-1:0] yellow;
  logic [$clog2(NUM_PHASES)-1:0] phase;
  logic busy_change;
  modport master(input sensor, output green, yellow, phase, busy_change);
  modport slave(output sensor, input green, yellow, phase, busy_change);
endinterface

// File: rtl/phase_traffic_controller_rr_phase_picker.sv
// rr_phase_picker: first requesting phase at or after start, wrapping modulo n
module rr_phase_picker #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] grant,
  output logic         valid
);
  logic [W-1:0] idx;
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(start) + i) % N);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/phase_traffic_controller.sv
// phase_traffic_controller: phased intersection controller with gap-out, max-green and round-robin selection
module phase_traffic_controller
  import tlc_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int NUM_PHASES = 8,
  parameter logic [NUM_PHASES*NUM_LANES-1:0] PHASE_LANES = PHASE_LANES_DEFAULT,
  parameter int DEFAULT_PHASE = 1,
  parameter int GAP_CYCLES = 5,
  parameter int MAX_GREEN_CYCLES = 10,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1
) (
  input logic clk,
  input logic reset,
  phase_traffic_controller_if.master bus
);
  localparam int PW = $clog2(NUM_PHASES);
  localparam int CW = $clog2(max4(GAP_CYCLES, MAX_GREEN_CYCLES, YELLOW_CYCLES, ALLRED_CYCLES) + 1);
  tlc_state_e state, state_nx;
  logic [PW-1:0] phase_q, phase_nx, start, grant;
  logic [CW-1:0] gap_ctr, gap_nx, max_ctr, max_nx, seg_ctr, seg_nx;
  logic [NUM_LANES-1:0] masks [NUM_PHASES];
  logic [NUM_LANES-1:0] mask;
  logic [NUM_PHASES-1:0] req;
  logic valid, own, other, gap_out, max_out, last;
  for (genvar q = 0; q < NUM_PHASES; q++) begin : g_req
    assign masks[q] = PHASE_LANES[q*NUM_LANES +: NUM_LANES];
    assign req[q] = |(bus.sensor & masks[q]);
  end
  assign mask = masks[phase_q];
  assign own = |(bus.sensor & mask);
  assign other = |(bus.sensor & ~mask);
  assign gap_out = !own && gap_ctr == CW'(GAP_CYCLES - 1);
  assign max_out = max_ctr == CW'(MAX_GREEN_CYCLES - 1);
  assign start = phase_q == PW'(NUM_PHASES - 1) ? '0 : phase_q + 1'b1;
  rr_phase_picker #(.N(NUM_PHASES), .W(PW)) u_pick (
    .req(req),
    .start(start),
    .grant(grant),
    .valid(valid)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_ALLRED;
      phase_q <= PW'(DEFAULT_PHASE);
      gap_ctr <= '0;
      max_ctr <= '0;
      seg_ctr <= '0;
    end else begin
      state <= state_nx;
      phase_q <= phase_nx;
      gap_ctr <= gap_nx;
      max_ctr <= max_nx;
      seg_ctr <= seg_nx;
    end
  end
  always_comb begin
    state_nx = state;
    phase_nx = phase_q;
    gap_nx = '0;
    max_nx = '0;
    seg_nx = '0;
    last = 1'b0;
    case (state)
      S_GREEN: begin
        gap_nx = own ? '0 : gap_out ? gap_ctr : gap_ctr + 1'b1;
        max_nx = max_out ? max_ctr : (other || max_ctr != '0) ? max_ctr + 1'b1 : '0;
        if (other && (gap_out || max_out)) begin
          state_nx = S_YELLOW;
          gap_nx = '0;
          max_nx = '0;
        end
      end
      S_YELLOW: begin
        last = seg_ctr == CW'(YELLOW_CYCLES - 1);
        state_nx = last ? S_ALLRED : S_YELLOW;
        seg_nx = last ? '0 : seg_ctr + 1'b1;
      end
      S_ALLRED: begin
        last = seg_ctr == CW'(ALLRED_CYCLES - 1);
        state_nx = last ? S_GREEN : S_ALLRED;
        seg_nx = last ? '0 : seg_ctr + 1'b1;
        phase_nx = !last ? phase_q : valid ? grant : PW'(DEFAULT_PHASE);
      end
      default: state_nx = S_ALLRED;
    endcase
  end
  assign bus.green = state == S_GREEN ? mask : '0;
  assign bus.yellow = state == S_YELLOW ? mask : '0;
  assign bus.phase = phase_q;
  assign bus.busy_change = state != S_GREEN;
endmodule
